// File: rtl/pingpong_buffer_ctrl.sv
// pingpong_buffer_ctrl
//   Sequencer for a two-bank (ping-pong) line buffer made of two DEPTH x DW
//   synchronous RAMs. A producer fills the "fill" bank while a consumer drains
//   the other bank. The banks swap only when the fill bank is full and the
//   drain bank is empty.
//
//   Handshakes:
//     Write: a word moves when wr_valid & wr_ready are both high at a rising
//     edge. wr_ready depends only on registered state.
//     Read: a word is requested when rd_req & rd_ready are both high at a
//     rising edge. rd_valid/rd_data follow one cycle later. If rd_req is high
//     while rd_ready is low, rd_underrun pulses one cycle later and the RAM is
//     not accessed.
//
//   Ports:
//     clk, reset          clock; asynchronous active-high reset
//     wr_valid/wr_data    producer word offer
//     wr_ready            fill bank has space
//     rd_req              consumer asks for the next word
//     rd_ready            drain bank holds readable data
//     rd_valid/rd_data    read word, one cycle after an accepted request
//     rd_underrun         request arrived while nothing was readable
//     ram1_* / ram2_*     enables, addresses and data for bank 0 / bank 1
//     wr_bank             current fill bank (0 = ram1); drain bank is ~wr_bank
//     swap_pulse          one-cycle pulse on each bank swap
//     swap_count          swaps since reset, wraps 255 -> 0
//
//   DEPTH must equal 2**AW: address counters wrap by natural overflow.
module pingpong_buffer_ctrl #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_req,
    output logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_underrun,
    output logic          ram1_we,
    output logic          ram1_re,
    output logic [AW-1:0] ram1_waddr,
    output logic [AW-1:0] ram1_raddr,
    output logic [DW-1:0] ram1_wdata,
    input  logic [DW-1:0] ram1_rdata,
    output logic          ram2_we,
    output logic          ram2_re,
    output logic [AW-1:0] ram2_waddr,
    output logic [AW-1:0] ram2_raddr,
    output logic [DW-1:0] ram2_wdata,
    input  logic [DW-1:0] ram2_rdata,
    output logic          wr_bank,
    output logic          swap_pulse,
    output logic [7:0]    swap_count
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic          r_wr_bank;
    logic [AW-1:0] r_waddr;
    logic [AW-1:0] r_raddr;
    logic [1:0]    r_full;
    logic          r_rd_bank_q;
    logic          r_rd_valid;
    logic          r_rd_underrun;
    logic          r_swap_pulse;
    logic [7:0]    r_swap_count;

    logic w_rd_bank;
    logic w_wr_ready;
    logic w_rd_ready;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_swap;

    assign w_rd_bank  = ~r_wr_bank;
    assign w_wr_ready = ~r_full[r_wr_bank];
    assign w_rd_ready = r_full[w_rd_bank];
    assign w_wr_acc   = wr_valid & w_wr_ready;
    assign w_rd_acc   = rd_req & w_rd_ready;
    // A swap needs a full fill bank, which forces wr_ready low, and an empty
    // drain bank, which forces rd_ready low. So no full flag can change on the
    // same edge as a swap.
    assign w_swap     = r_full[r_wr_bank] & ~r_full[w_rd_bank];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_bank     <= 1'b0;
            r_waddr       <= '0;
            r_raddr       <= '0;
            r_full        <= 2'b00;
            r_rd_bank_q   <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_underrun <= 1'b0;
            r_swap_pulse  <= 1'b0;
            r_swap_count  <= 8'd0;
        end else begin
            r_rd_valid    <= w_rd_acc;
            r_rd_underrun <= rd_req & ~w_rd_ready;
            r_swap_pulse  <= w_swap;

            if (w_swap) begin
                r_wr_bank    <= ~r_wr_bank;
                r_swap_count <= r_swap_count + 8'd1;
            end

            if (w_wr_acc) begin
                r_waddr <= r_waddr + 1'b1;
                if (r_waddr == LAST_ADDR) begin
                    r_full[r_wr_bank] <= 1'b1;
                end
            end

            // The write and the read always target different banks, so the
            // set and clear of full flags never touch the same bit.
            if (w_rd_acc) begin
                r_raddr     <= r_raddr + 1'b1;
                r_rd_bank_q <= w_rd_bank;
                if (r_raddr == LAST_ADDR) begin
                    r_full[w_rd_bank] <= 1'b0;
                end
            end
        end
    end

    assign wr_ready    = w_wr_ready;
    assign rd_ready    = w_rd_ready;
    assign rd_valid    = r_rd_valid;
    assign rd_underrun = r_rd_underrun;
    assign rd_data     = r_rd_bank_q ? ram2_rdata : ram1_rdata;

    // Both banks see the same addresses and write data. Only the enables
    // decide which bank is touched.
    assign ram1_we    = w_wr_acc & ~r_wr_bank;
    assign ram2_we    = w_wr_acc & r_wr_bank;
    assign ram1_re    = w_rd_acc & ~w_rd_bank;
    assign ram2_re    = w_rd_acc & w_rd_bank;
    assign ram1_waddr = r_waddr;
    assign ram2_waddr = r_waddr;
    assign ram1_raddr = r_raddr;
    assign ram2_raddr = r_raddr;
    assign ram1_wdata = wr_data;
    assign ram2_wdata = wr_data;

    assign wr_bank    = r_wr_bank;
    assign swap_pulse = r_swap_pulse;
    assign swap_count = r_swap_count;

endmodule
